// File: rtl/fizzbuzz_stream_ctrl_if.sv
// fizzbuzz_stream_ctrl_if
//   Token stream between the fizz/buzz run controller and its consumer.
//   master: producer side (drives token + valid, samples ready)
//   slave : consumer side (samples token + valid, drives ready)
//   Signals:
//     out_valid     token available
//     out_ready     consumer accepts token
//     out_value     counter value carried by the token
//     out_fizz      value divisible by fizz divisor
//     out_buzz      value divisible by buzz divisor
//     out_fizzbuzz  both of the above
//     out_last      final token of the run
interface fizzbuzz_stream_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_value;
  logic             out_fizz;
  logic             out_buzz;
  logic             out_fizzbuzz;
  logic             out_last;

  modport master (
    output out_valid,
    output out_value,
    output out_fizz,
    output out_buzz,
    output out_fizzbuzz,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_value,
    input  out_fizz,
    input  out_buzz,
    input  out_fizzbuzz,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fizzbuzz_stream_ctrl.sv
// fizzbuzz_stream_ctrl
//   Run controller for the fizz/buzz classification counter. A start in IDLE
//   latches a run length and two divisors, then the values 0..len-1 are
//   streamed out with divisibility flags taken from incremental residue
//   counters.
//   Ports:
//     clk       clock, rising edge
//     reset     synchronous, active-high
//     start     run request (sampled only in IDLE)
//     abort     terminate a run in progress
//     cfg_len   tokens in the run
//     cfg_fizz  fizz divisor
//     cfg_buzz  buzz divisor
//     busy      high while running
//     done      one-cycle pulse after the last token is accepted
//     cfg_err   one-cycle pulse when a start has a zero divisor
//     tok       token stream (master side)
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no run; stream outputs forced to 0; start/config evaluated
//   S_RUN  | token presented every cycle, advances on out_ready
module fizzbuzz_stream_ctrl #(
  parameter int CNT_W = 8,
  parameter int DIV_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [CNT_W-1:0]       cfg_len,
  input  logic [DIV_W-1:0]       cfg_fizz,
  input  logic [DIV_W-1:0]       cfg_buzz,
  output logic                   busy,
  output logic                   done,
  output logic                   cfg_err,
  fizzbuzz_stream_ctrl_if.master tok
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] value_q, value_d;
  logic [DIV_W-1:0] fizz_q, fizz_d;
  logic [DIV_W-1:0] buzz_q, buzz_d;
  logic [DIV_W-1:0] rf_q, rf_d;
  logic [DIV_W-1:0] rb_q, rb_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic run;
  logic last;
  logic hs;

  assign run  = (state_q == S_RUN);
  assign last = (value_q == len_q - 1'b1);
  assign hs   = run & tok.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      value_q <= '0;
      fizz_q  <= '0;
      buzz_q  <= '0;
      rf_q    <= '0;
      rb_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      value_q <= value_d;
      fizz_q  <= fizz_d;
      buzz_q  <= buzz_d;
      rf_q    <= rf_d;
      rb_q    <= rb_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    value_d = value_q;
    fizz_d  = fizz_q;
    buzz_d  = buzz_q;
    rf_d    = rf_q;
    rb_d    = rb_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort in IDLE only matters as a veto on a simultaneous start
        if (start && !abort) begin
          if (cfg_fizz == '0 || cfg_buzz == '0) begin
            err_d = 1'b1;
          end else if (cfg_len == '0) begin
            done_d = 1'b1;
          end else begin
            len_d   = cfg_len;
            fizz_d  = cfg_fizz;
            buzz_d  = cfg_buzz;
            value_d = '0;
            rf_d    = '0;
            rb_d    = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          // a same-cycle handshake is discarded
          state_d = S_IDLE;
        end else if (hs) begin
          if (last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            value_d = value_q + 1'b1;
            rf_d    = (rf_q == fizz_q - 1'b1) ? '0 : rf_q + 1'b1;
            rb_d    = (rb_q == buzz_q - 1'b1) ? '0 : rb_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stream outputs are gated by state so IDLE always shows zeros even
  // though value/residue registers keep their last run contents.
  assign busy             = run;
  assign done             = done_q;
  assign cfg_err          = err_q;
  assign tok.out_valid    = run;
  assign tok.out_value    = run ? value_q : '0;
  assign tok.out_fizz     = run && (rf_q == '0);
  assign tok.out_buzz     = run && (rb_q == '0);
  assign tok.out_fizzbuzz = run && (rf_q == '0) && (rb_q == '0);
  assign tok.out_last     = run && last;

endmodule

// File: tb/tb_fizzbuzz_stream_ctrl.sv
module tb_fizzbuzz_stream_ctrl;

  localparam int CNT_W = 8;
  localparam int DIV_W = 4;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_len;
  logic [DIV_W-1:0] cfg_fizz;
  logic [DIV_W-1:0] cfg_buzz;
  logic             busy;
  logic             done;
  logic             cfg_err;

  int tests;
  int failed;

  fizzbuzz_stream_ctrl_if #(.CNT_W(CNT_W)) tok ();

  fizzbuzz_stream_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .cfg_len  (cfg_len),
    .cfg_fizz (cfg_fizz),
    .cfg_buzz (cfg_buzz),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .tok      (tok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All stream/status outputs at their idle values
  task automatic check_idle(input string tag);
    check({tag, " valid"}, 32'(tok.out_valid), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " value"}, 32'(tok.out_value), 0);
    check({tag, " fizz"}, 32'(tok.out_fizz), 0);
    check({tag, " buzz"}, 32'(tok.out_buzz), 0);
    check({tag, " fizzbuzz"}, 32'(tok.out_fizzbuzz), 0);
    check({tag, " last"}, 32'(tok.out_last), 0);
  endtask

  // Called at a negedge; issues start immediately and checks every token
  // against plain modulo arithmetic on the expected value.
  task automatic run_stream(input int len, input int f, input int b,
                            input bit rnd_ready, input bit poke);
    int  v;
    int  cyc;
    bit  fin;
    bit  rdy;
    string t;
    v   = 0;
    cyc = 0;
    fin = 1'b0;
    start    = 1'b1;
    cfg_len  = CNT_W'(len);
    cfg_fizz = DIV_W'(f);
    cfg_buzz = DIV_W'(b);
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < len * 8 + 20) begin
      t = $sformatf("len%0d v%0d", len, v);
      check({t, " valid"}, 32'(tok.out_valid), 1);
      check({t, " busy"}, 32'(busy), 1);
      check({t, " value"}, 32'(tok.out_value), 32'(v));
      check({t, " fizz"}, 32'(tok.out_fizz), 32'(v % f == 0));
      check({t, " buzz"}, 32'(tok.out_buzz), 32'(v % b == 0));
      check({t, " fizzbuzz"}, 32'(tok.out_fizzbuzz), 32'((v % f == 0) && (v % b == 0)));
      check({t, " last"}, 32'(tok.out_last), 32'(v == len - 1));
      check({t, " done"}, 32'(done), 0);
      rdy = rnd_ready ? bit'($urandom_range(1, 0)) : 1'b1;
      tok.out_ready = rdy;
      // start during RUN must be ignored, even with a different valid config
      if (poke && $urandom_range(3, 0) == 0) begin
        start    = 1'b1;
        cfg_len  = 8'd3;
        cfg_fizz = 4'd2;
        cfg_buzz = 4'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (rdy) begin
        if (v == len - 1) fin = 1'b1;
        else v++;
      end
    end
    start = 1'b0;
    check($sformatf("len%0d finished in budget", len), 32'(fin), 1);
    check($sformatf("len%0d done pulse", len), 32'(done), 1);
    check_idle($sformatf("len%0d after run", len));
    @(negedge clk);
    check($sformatf("len%0d done one cycle", len), 32'(done), 0);
    check($sformatf("len%0d stays idle", len), 32'(tok.out_valid), 0);
  endtask

  // Start a run and let it advance with ready high until out_value hits target
  task automatic run_to(input int len, input int target);
    start    = 1'b1;
    cfg_len  = CNT_W'(len);
    cfg_fizz = 4'd3;
    cfg_buzz = 4'd5;
    tok.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 64 && int'(tok.out_value) != target; i++) @(negedge clk);
    check($sformatf("reached value %0d", target), 32'(tok.out_value), 32'(target));
  endtask

  initial begin
    tests         = 0;
    failed        = 0;
    reset         = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    cfg_len       = '0;
    cfg_fizz      = '0;
    cfg_buzz      = '0;
    tok.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset done", 32'(done), 0);
    check("reset cfg_err", 32'(cfg_err), 0);
    reset = 1'b0;
    @(negedge clk);

    // basic run, ready held high
    run_stream(16, 3, 5, 1'b0, 1'b0);

    // backpressure, plus starts poked during RUN
    run_stream(16, 3, 5, 1'b1, 1'b1);

    // zero divisor rejected
    start = 1'b1; cfg_len = 8'd5; cfg_fizz = 4'd3; cfg_buzz = 4'd0;
    @(negedge clk);
    start = 1'b0;
    check("buzz0 cfg_err", 32'(cfg_err), 1);
    check("buzz0 done", 32'(done), 0);
    check_idle("buzz0");
    @(negedge clk);
    check("buzz0 cfg_err one cycle", 32'(cfg_err), 0);
    check("buzz0 still idle", 32'(busy), 0);

    // zero length: done, no tokens
    start = 1'b1; cfg_len = 8'd0; cfg_fizz = 4'd3; cfg_buzz = 4'd5;
    @(negedge clk);
    start = 1'b0;
    check("len0 done", 32'(done), 1);
    check("len0 cfg_err", 32'(cfg_err), 0);
    check_idle("len0");
    @(negedge clk);
    check("len0 done one cycle", 32'(done), 0);
    check("len0 no valid", 32'(tok.out_valid), 0);

    // divisor 1: every flag set
    run_stream(4, 1, 1, 1'b1, 1'b0);

    // abort at value 7, handshake in the same cycle is dropped
    run_to(20, 7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort done", 32'(done), 0);
    check_idle("abort");
    // immediate restart with cleared residues
    run_stream(2, 3, 5, 1'b0, 1'b0);

    // reset mid-run at value 9
    run_to(20, 9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("midrun reset");
    check("midrun reset done", 32'(done), 0);
    @(negedge clk);
    check("after reset idle", 32'(tok.out_valid), 0);
    check("after reset no done", 32'(done), 0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; cfg_len = 8'd5; cfg_fizz = 4'd3; cfg_buzz = 4'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check_idle("start+abort");
    check("start+abort done", 32'(done), 0);
    check("start+abort cfg_err", 32'(cfg_err), 0);
    @(negedge clk);
    check("start+abort still idle", 32'(busy), 0);

    // abort in IDLE alone has no effect; a following run is normal
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("idle abort");

    // randomized short runs
    for (int r = 0; r < 4; r++) begin
      run_stream(int'($urandom_range(30, 1)), int'($urandom_range(15, 1)),
                 int'($urandom_range(15, 1)), 1'b1, 1'b1);
    end

    // maximum length
    run_stream(255, 15, 4, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
